branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Parametrised dynamic branch predictor (BHT + BTB) for the 5-stage pipeline: IF-stage lookup
//  supplies predicted direction/target for PC_Src; ID-stage branch resolution writes back outcome.
//  Replaces static not-taken + flush-on-taken; adds saturating history, tagged targets, statistics.
// PARAMETERS
//  XLEN      32  address/data width
//  ENTRIES   64  table entries; power of 2, >=2; INDEX_W = log2(ENTRIES)
//  CNT_BITS  2   history counter width, 1..4; taken when counter MSB = 1
//  STAT_W    32  width of statistics counters
// PORTS
//  clk_i               in   1        clock, all state on rising edge
//  rst_i               in   1        reset, synchronous, active-low
//  lookup_pc_i         in   XLEN     IF-stage PC
//  predict_hit_o       out  1        valid entry with matching tag
//  predict_taken_o     out  1        hit & counter MSB
//  predict_target_o    out  XLEN     stored target; 0 when !hit
//  update_valid_i      in   1        resolved branch present this cycle
//  update_pc_i         in   XLEN     PC of resolved branch
//  update_taken_i      in   1        actual direction
//  update_target_i     in   XLEN     actual target (PC + imm)
//  update_mispredict_i in   1        ID stage found prediction wrong (qualified by update_valid_i)
//  branch_count_o      out  STAT_W   resolved branches since reset
//  mispredict_count_o  out  STAT_W   mispredictions since reset
// BEHAVIOUR
//  - Index = pc[INDEX_W+1:2]; tag = pc[XLEN-1:INDEX_W+2]; pc[1:0] ignored.
//  - Lookup combinational from registered table, zero latency; no read-after-write bypass:
//    lookup and update to same index in one cycle -> lookup returns pre-update contents.
//  - Reset (rst_i=0 at edge): all valid bits 0, counters = WNT (2^(CNT_BITS-1)-1), tags/targets 0,
//    both stat counters 0. Outputs after reset: hit 0, taken 0, target 0, counts 0.
//    Update asserted during reset is discarded.
//  - Update, entry hit (valid & tag match): counter +1 if taken, -1 if not, saturating at
//    0 and 2^CNT_BITS-1; target overwritten only when update_taken_i=1.
//  - Update, miss (invalid or tag mismatch): allocate/replace: valid=1, tag written, counter =
//    WT (2^(CNT_BITS-1)) if taken else WNT, target = update_target_i if taken else 0.
//  - Writes visible to lookup the cycle after the update edge (1-cycle update latency).
//  - branch_count_o += 1 per update_valid_i; mispredict_count_o += 1 per update_valid_i &
//    update_mispredict_i; both saturate at all-ones (no wrap).
//  - CNT_BITS=1: counter 0/1, WNT=0, WT=1; MSB rule unchanged.
//  - No handshake/back-pressure: one update per cycle accepted unconditionally.
// STRUCTURE
//  - Package bp_pkg: function cnt_next(cnt, taken) (saturating step), WNT/WT constant functions
//    of CNT_BITS, index/tag extraction functions of XLEN/INDEX_W.
//  - One sub-module: bp_sat_counter (CNT_BITS-wide saturating up/down counter, sync active-low
//    reset to WNT, load port for allocation); instantiated ENTRIES times via generate.
//  - Tag/target/valid arrays are plain flop arrays in top; stat counters inline.
// TESTING (defaults unless noted)
//  1 Reset: hold rst_i=0 2 cycles with update_valid_i=1 -> after release, lookup any PC:
//    hit 0, taken 0, target 0; counts 0.
//  2 Allocate: update pc=0x100 taken target=0x80 -> next cycle lookup 0x100: hit 1, taken 1,
//    target 0x80; branch_count 1.
//  3 Saturation: 4 taken updates to 0x100 then 1 not-taken -> taken 1 (3->2); 2 further
//    not-taken -> taken 0, counter 0; another not-taken keeps 0; 2 taken -> taken 1.
//  4 Aliasing: allocate 0x100 taken, then update 0x200 (same index, other tag) not-taken ->
//    lookup 0x100 hit 0; lookup 0x200 hit 1, taken 0, target 0.
//  5 Same-cycle: lookup 0x100 while updating 0x100 not-taken->saturated counter 3 -> that cycle
//    taken reflects old value; next cycle reflects new.
//  6 Stats: STAT_W=4, 20 updates all mispredict -> both counts stick at 15; CNT_BITS=1 run of
//    test 3 direction flips on every update.

Source files
------------

// File: rtl/bp_pkg.sv
// Package: bp_pkg
// Shared helpers for the dynamic branch predictor.
//   wnt / wt    : weakly-not-taken / weakly-taken counter values for a counter width
//   cnt_next    : saturating up/down step of a history counter
//   pc_index    : table index taken from pc[INDEX_W+1:2]
//   pc_tag      : tag taken from pc[XLEN-1:INDEX_W+2]
// The helpers work on 64-bit PCs and plain integers so that modules with
// different XLEN/INDEX_W/CNT_BITS can share them. Callers cast the results
// to their own widths.
package bp_pkg;

  function automatic int unsigned wnt(input int unsigned cnt_bits);
    return (32'd1 << (cnt_bits - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned wt(input int unsigned cnt_bits);
    return 32'd1 << (cnt_bits - 32'd1);
  endfunction

  function automatic int unsigned cnt_next(input int unsigned cnt,
                                           input logic        taken,
                                           input int unsigned cnt_bits);
    int unsigned max_v;
    max_v = (32'd1 << cnt_bits) - 32'd1;
    if (taken) return (cnt == max_v) ? cnt : cnt + 32'd1;
    else       return (cnt == 32'd0) ? cnt : cnt - 32'd1;
  endfunction

  function automatic int unsigned pc_index(input logic [63:0]  pc,
                                           input int unsigned  index_w);
    logic [63:0] mask;
    mask = (64'd1 << index_w) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc,
                                         input int unsigned index_w);
    return pc >> (index_w + 32'd2);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Interface: branch_predictor_if
// Groups the IF-stage lookup, ID-stage update and statistics signals of the
// branch predictor.
//   master : pipeline side (drives lookup/update, receives predictions/stats)
//   slave  : predictor side
interface branch_predictor_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);
  // IF-stage lookup
  logic [XLEN-1:0]   lookup_pc_i;
  logic              predict_hit_o;
  logic              predict_taken_o;
  logic [XLEN-1:0]   predict_target_o;
  // ID-stage resolution
  logic              update_valid_i;
  logic [XLEN-1:0]   update_pc_i;
  logic              update_taken_i;
  logic [XLEN-1:0]   update_target_i;
  logic              update_mispredict_i;
  // Statistics
  logic [STAT_W-1:0] branch_count_o;
  logic [STAT_W-1:0] mispredict_count_o;

  modport master (
    output lookup_pc_i, update_valid_i, update_pc_i, update_taken_i,
           update_target_i, update_mispredict_i,
    input  predict_hit_o, predict_taken_o, predict_target_o,
           branch_count_o, mispredict_count_o
  );

  modport slave (
    input  lookup_pc_i, update_valid_i, update_pc_i, update_taken_i,
           update_target_i, update_mispredict_i,
    output predict_hit_o, predict_taken_o, predict_target_o,
           branch_count_o, mispredict_count_o
  );
endinterface

// File: rtl/bp_sat_counter.sv
// Module: bp_sat_counter
// CNT_BITS-wide saturating up/down history counter for one table entry.
//   clk_i    : clock
//   rst_i    : synchronous active-low reset, counter returns to weakly-not-taken
//   step_en  : move one step towards taken/not-taken
//   taken    : step direction
//   load_en  : overwrite counter (entry allocation); wins over step_en
//   load_val : value loaded on allocation
//   cnt      : current counter value
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_BITS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                step_en,
  input  logic                taken,
  input  logic                load_en,
  input  logic [CNT_BITS-1:0] load_val,
  output logic [CNT_BITS-1:0] cnt
);

  localparam logic [CNT_BITS-1:0] RST_VAL = CNT_BITS'(wnt(CNT_BITS));

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_i)       cnt <= RST_VAL;
    else if (load_en) cnt <= load_val;
    else if (step_en) cnt <= CNT_BITS'(cnt_next(32'(cnt), taken, CNT_BITS));
  end

endmodule

// File: rtl/branch_predictor.sv
// Module: branch_predictor
// Direct-mapped dynamic branch predictor: BHT (saturating counters) + tagged BTB.
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-low reset
//   bp    : branch_predictor_if.slave
//           lookup_pc_i -> predict_hit_o / predict_taken_o / predict_target_o
//                          (combinational from the registered table)
//           update_*_i  -> table write on the next rising edge
//           branch_count_o / mispredict_count_o : saturating statistics
// A lookup and an update to the same index in one cycle returns the
// pre-update contents; the write is visible the following cycle.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int CNT_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  branch_predictor_if.slave bp
);

  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = XLEN - INDEX_W - 2;

  localparam logic [CNT_BITS-1:0] WNT_VAL = CNT_BITS'(wnt(CNT_BITS));
  localparam logic [CNT_BITS-1:0] WT_VAL  = CNT_BITS'(wt(CNT_BITS));

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

  logic [STAT_W-1:0]   branch_count_q;
  logic [STAT_W-1:0]   mispredict_count_q;

  // ---------------------------------------------------------------- lookup
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;

  assign lk_idx = INDEX_W'(pc_index(64'(bp.lookup_pc_i), INDEX_W));
  assign lk_tag = TAG_W'(pc_tag(64'(bp.lookup_pc_i), INDEX_W));
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign bp.predict_hit_o    = lk_hit;
  assign bp.predict_taken_o  = lk_hit && cnt_q[lk_idx][CNT_BITS-1];
  assign bp.predict_target_o = lk_hit ? target_q[lk_idx] : '0;

  // ---------------------------------------------------------------- update
  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;

  assign up_idx = INDEX_W'(pc_index(64'(bp.update_pc_i), INDEX_W));
  assign up_tag = TAG_W'(pc_tag(64'(bp.update_pc_i), INDEX_W));
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // A hit steps the existing history; a miss (re)allocates the entry with a
  // weak counter biased towards the resolved direction.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
    logic sel;
    assign sel = bp.update_valid_i && (up_idx == INDEX_W'(g));

    bp_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .step_en  (sel && up_hit),
      .taken    (bp.update_taken_i),
      .load_en  (sel && !up_hit),
      .load_val (bp.update_taken_i ? WT_VAL : WNT_VAL),
      .cnt      (cnt_q[g])
    );
  end

  // NOTE: the tag/target/valid arrays are reset explicitly because a lookup
  // must report a clean miss with target 0 right after reset; a plain
  // storage RAM would normally be left unreset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (bp.update_valid_i) begin
      if (!up_hit) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bp.update_taken_i ? bp.update_target_i : '0;
      end else if (bp.update_taken_i) begin
        // Not-taken outcomes carry no useful target; keep the last known one.
        target_q[up_idx] <= bp.update_target_i;
      end
    end
  end

  // ------------------------------------------------------------ statistics
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (bp.update_valid_i) begin
      if (branch_count_q != '1)
        branch_count_q <= branch_count_q + 1'b1;
      if (bp.update_mispredict_i && (mispredict_count_q != '1))
        mispredict_count_q <= mispredict_count_q + 1'b1;
    end
  end

  assign bp.branch_count_o     = branch_count_q;
  assign bp.mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench: tb_branch_predictor
// Drives two predictors with identical stimulus: a default configuration
// (CNT_BITS=2, STAT_W=32) and a narrow one (CNT_BITS=1, STAT_W=4).
// A reference model per configuration pushes expected outputs to a
// scoreboard queue when a cycle's stimulus is driven; the entries are popped
// and compared when the outputs are sampled, 1 time unit after the falling edge.
module tb_branch_predictor;

  typedef struct {
    string       name;
    int          dut;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] lookup_pc  = '0;
  logic        upd_valid  = 1'b0;
  logic [31:0] upd_pc     = '0;
  logic        upd_taken  = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mis    = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  exp_t sb[$];

  // observed values of the most recent step, per DUT
  logic        o_hit   [2];
  logic        o_taken [2];
  logic [31:0] o_tgt   [2];
  logic [31:0] o_bc    [2];
  logic [31:0] o_mc    [2];

  always #5 clk_i = ~clk_i;

  branch_predictor_if #(.XLEN(32), .STAT_W(32)) if0 ();
  branch_predictor_if #(.XLEN(32), .STAT_W(4))  if1 ();

  assign if0.lookup_pc_i         = lookup_pc;
  assign if0.update_valid_i      = upd_valid;
  assign if0.update_pc_i         = upd_pc;
  assign if0.update_taken_i      = upd_taken;
  assign if0.update_target_i     = upd_target;
  assign if0.update_mispredict_i = upd_mis;
  assign if1.lookup_pc_i         = lookup_pc;
  assign if1.update_valid_i      = upd_valid;
  assign if1.update_pc_i         = upd_pc;
  assign if1.update_taken_i      = upd_taken;
  assign if1.update_target_i     = upd_target;
  assign if1.update_mispredict_i = upd_mis;

  branch_predictor #(.XLEN(32), .ENTRIES(64), .CNT_BITS(2), .STAT_W(32)) u_dut0 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bp    (if0)
  );

  branch_predictor #(.XLEN(32), .ENTRIES(64), .CNT_BITS(1), .STAT_W(4)) u_dut1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bp    (if1)
  );

  // ------------------------------------------------------ reference model
  bit          m_valid [2][64];
  int unsigned m_tag   [2][64];
  int unsigned m_cnt   [2][64];
  logic [31:0] m_tgt   [2][64];
  longint      m_bc    [2];
  longint      m_mc    [2];

  function automatic int unsigned cbits(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic longint smax(input int d);
    return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd15;
  endfunction

  function automatic void m_reset(input int d);
    for (int i = 0; i < 64; i++) begin
      m_valid[d][i] = 1'b0;
      m_tag[d][i]   = 0;
      m_cnt[d][i]   = (1 << (cbits(d) - 1)) - 1;
      m_tgt[d][i]   = '0;
    end
    m_bc[d] = 0;
    m_mc[d] = 0;
  endfunction

  function automatic exp_t m_expect(input int d, input string name, input logic [31:0] pc);
    exp_t        e;
    int unsigned idx;
    int unsigned tg;
    idx      = (pc >> 2) & 32'd63;
    tg       = pc >> 8;
    e.name   = name;
    e.dut    = d;
    e.hit    = m_valid[d][idx] && (m_tag[d][idx] == tg);
    e.taken  = e.hit && (((m_cnt[d][idx] >> (cbits(d) - 1)) & 1) == 1);
    e.target = e.hit ? m_tgt[d][idx] : 32'd0;
    e.bc     = 32'(m_bc[d]);
    e.mc     = 32'(m_mc[d]);
    return e;
  endfunction

  function automatic void m_update(input int d, input logic [31:0] pc, input logic t,
                                   input logic [31:0] tgt, input logic mis);
    int unsigned idx;
    int unsigned tg;
    int unsigned top;
    idx = (pc >> 2) & 32'd63;
    tg  = pc >> 8;
    top = (1 << cbits(d)) - 1;
    if (m_valid[d][idx] && (m_tag[d][idx] == tg)) begin
      if (t) begin
        if (m_cnt[d][idx] < top) m_cnt[d][idx]++;
        m_tgt[d][idx] = tgt;
      end else begin
        if (m_cnt[d][idx] > 0) m_cnt[d][idx]--;
      end
    end else begin
      m_valid[d][idx] = 1'b1;
      m_tag[d][idx]   = tg;
      m_cnt[d][idx]   = t ? (1 << (cbits(d) - 1)) : (1 << (cbits(d) - 1)) - 1;
      m_tgt[d][idx]   = t ? tgt : 32'd0;
    end
    if (m_bc[d] < smax(d)) m_bc[d]++;
    if (mis && (m_mc[d] < smax(d))) m_mc[d]++;
  endfunction

  // ------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic capture();
    o_hit[0]   = if0.predict_hit_o;
    o_taken[0] = if0.predict_taken_o;
    o_tgt[0]   = if0.predict_target_o;
    o_bc[0]    = if0.branch_count_o;
    o_mc[0]    = if0.mispredict_count_o;
    o_hit[1]   = if1.predict_hit_o;
    o_taken[1] = if1.predict_taken_o;
    o_tgt[1]   = if1.predict_target_o;
    o_bc[1]    = 32'(if1.branch_count_o);
    o_mc[1]    = 32'(if1.mispredict_count_o);
  endtask

  // One clock cycle: drive lookup + optional update, compare outputs before
  // the rising edge, then advance the model past that edge.
  task automatic step(input string name, input logic [31:0] lpc, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                      input logic um);
    exp_t e;
    @(negedge clk_i);
    lookup_pc  = lpc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utgt;
    upd_mis    = um;
    for (int d = 0; d < 2; d++) sb.push_back(m_expect(d, name, lpc));
    #1;
    capture();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s.d%0d.hit", e.name, e.dut),    32'(o_hit[e.dut]),   32'(e.hit));
      check($sformatf("%s.d%0d.taken", e.name, e.dut),  32'(o_taken[e.dut]), 32'(e.taken));
      check($sformatf("%s.d%0d.target", e.name, e.dut), o_tgt[e.dut],        e.target);
      check($sformatf("%s.d%0d.bcnt", e.name, e.dut),   o_bc[e.dut],         e.bc);
      check($sformatf("%s.d%0d.mcnt", e.name, e.dut),   o_mc[e.dut],         e.mc);
    end
    @(posedge clk_i);
    if (uv)
      for (int d = 0; d < 2; d++) m_update(d, upc, ut, utgt, um);
  endtask

  task automatic look(input string name, input logic [31:0] lpc);
    step(name, lpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic upd(input string name, input logic [31:0] pc, input logic t,
                     input logic [31:0] tgt, input logic mis);
    step(name, pc, 1'b1, pc, t, tgt, mis);
  endtask

  // Reset held two cycles with an update pending; the update must be dropped.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i      = 1'b0;
    upd_valid  = 1'b1;
    upd_pc     = 32'h100;
    upd_taken  = 1'b1;
    upd_target = 32'h80;
    upd_mis    = 1'b1;
    repeat (2) @(posedge clk_i);
    for (int d = 0; d < 2; d++) m_reset(d);
    @(negedge clk_i);
    rst_i     = 1'b1;
    upd_valid = 1'b0;
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] pcs [6];
    pcs[0] = 32'h100;  pcs[1] = 32'h200;  pcs[2] = 32'h104;
    pcs[3] = 32'h306;  pcs[4] = 32'h1100; pcs[5] = 32'hFFFF_FFFC;
    for (int d = 0; d < 2; d++) m_reset(d);

    // 1: reset
    do_reset();
    look("rst", 32'h100);
    check("rst.hit",  32'(o_hit[0]), 32'd0);
    check("rst.bcnt", o_bc[0],       32'd0);
    check("rst.mcnt", o_mc[1],       32'd0);

    // 2: allocate
    upd("alloc", 32'h100, 1'b1, 32'h80, 1'b1);
    look("alloc.look", 32'h100);
    check("alloc.hit",    32'(o_hit[0]),   32'd1);
    check("alloc.taken",  32'(o_taken[0]), 32'd1);
    check("alloc.target", o_tgt[0],        32'h80);
    check("alloc.bcnt",   o_bc[0],         32'd1);

    // 3: saturation
    repeat (4) upd("sat.t", 32'h100, 1'b1, 32'h80, 1'b0);
    upd("sat.nt1", 32'h100, 1'b0, 32'h80, 1'b1);
    look("sat.after_nt1", 32'h100);
    check("sat.3to2.taken", 32'(o_taken[0]), 32'd1);
    check("sat.w1.flip",    32'(o_taken[1]), 32'd0);
    repeat (2) upd("sat.nt", 32'h100, 1'b0, 32'h80, 1'b0);
    upd("sat.nt_floor", 32'h100, 1'b0, 32'h80, 1'b0);
    look("sat.floor", 32'h100);
    check("sat.floor.taken", 32'(o_taken[0]), 32'd0);
    repeat (2) upd("sat.t2", 32'h100, 1'b1, 32'h84, 1'b0);
    look("sat.recover", 32'h100);
    check("sat.recover.taken", 32'(o_taken[0]), 32'd1);
    check("sat.recover.tgt",   o_tgt[0],        32'h84);

    // 4: aliasing
    upd("alias.a", 32'h100, 1'b1, 32'h80, 1'b0);
    upd("alias.b", 32'h200, 1'b0, 32'h90, 1'b1);
    look("alias.old", 32'h100);
    check("alias.old.hit", 32'(o_hit[0]), 32'd0);
    look("alias.new", 32'h200);
    check("alias.new.hit", 32'(o_hit[0]), 32'd1);
    check("alias.new.tgt", o_tgt[0],      32'd0);

    // 5: same-cycle lookup/update (counter 2 -> 1 on default, 1 -> 0 on narrow)
    upd("same.alloc", 32'h100, 1'b1, 32'h40, 1'b0);
    upd("same.nt",    32'h100, 1'b0, 32'h40, 1'b0);
    check("same.old.taken0", 32'(o_taken[0]), 32'd1);
    check("same.old.taken1", 32'(o_taken[1]), 32'd1);
    look("same.new", 32'h100);
    check("same.new.taken0", 32'(o_taken[0]), 32'd0);
    check("same.new.taken1", 32'(o_taken[1]), 32'd0);

    // mixed traffic over several indices, tags and misaligned PCs
    for (int i = 0; i < 150; i++) begin
      logic [31:0] p;
      logic [31:0] q;
      p = pcs[$urandom_range(5)];
      q = pcs[$urandom_range(5)];
      step("mix", q, 1'($urandom_range(1)), p, 1'($urandom_range(1)),
           $urandom & 32'hFFFF_FFFC, 1'($urandom_range(1)));
    end

    // 6: statistics saturation
    do_reset();
    for (int i = 0; i < 20; i++) upd("stat", pcs[i % 6], 1'(i % 2), 32'h200, 1'b1);
    look("stat.end", 32'h100);
    check("stat.bcnt.w4",  o_bc[1], 32'd15);
    check("stat.mcnt.w4",  o_mc[1], 32'd15);
    check("stat.bcnt.w32", o_bc[0], 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
